// File: rtl/dcd_var_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcd_var_sched_if: request, state-RAM and decoder bundle of dcd_var_sched    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface dcd_var_sched_if #(
  parameter int GROUP_W = 4,
  parameter int WIDTH   = 3
);
  logic                 start_i;
  logic                 abort_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 found_o;
  logic [GROUP_W+2:0]   var_idx_o;
  logic                 rd_en_o;
  logic [GROUP_W-1:0]   rd_addr_o;
  logic [8*WIDTH-1:0]   rd_data_i;
  logic                 wr_en_o;
  logic [GROUP_W-1:0]   wr_addr_o;
  logic [8*WIDTH-1:0]   wr_data_o;
  logic [8*WIDTH-1:0]   dcd_value_o;
  logic [1:0]           dcd_lock_cnt_o;
  logic [7:0]           dcd_index_i;
  logic [1:0]           dcd_lock_cnt_i;

  // Environment side: requester, state RAM and decoder.
  modport master (
    output start_i, abort_i, rd_data_i, dcd_index_i, dcd_lock_cnt_i,
    input  busy_o, done_o, found_o, var_idx_o, rd_en_o, rd_addr_o,
           wr_en_o, wr_addr_o, wr_data_o, dcd_value_o, dcd_lock_cnt_o
  );

  // Scheduler side.
  modport slave (
    input  start_i, abort_i, rd_data_i, dcd_index_i, dcd_lock_cnt_i,
    output busy_o, done_o, found_o, var_idx_o, rd_en_o, rd_addr_o,
           wr_en_o, wr_addr_o, wr_data_o, dcd_value_o, dcd_lock_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/dcd_var_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcd_var_sched: wrapping group scan of the variable-state RAM for decisions  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module dcd_var_sched #(
  parameter int               NUM_GROUPS   = 16,
  parameter int               GROUP_W      = 4,
  parameter int               WIDTH        = 3,
  parameter logic [WIDTH-1:0] DECIDE_VALUE = 3'b010
) (
  input  wire logic            clk,
  input  wire logic            rst,
  dcd_var_sched_if.slave       bus
);

  localparam int               CNT_W  = GROUP_W + 1;
  localparam logic [CNT_W-1:0] c_num  = CNT_W'(NUM_GROUPS);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [GROUP_W-1:0]  r_ptr;
  logic [CNT_W-1:0]    r_issued;
  logic [CNT_W-1:0]    r_evald;
  logic                r_eval_vld;
  logic [GROUP_W-1:0]  r_eval_grp;
  logic [GROUP_W-1:0]  r_last_grp;
  logic                r_found;
  logic [GROUP_W+2:0]  r_var_idx;
  logic [GROUP_W-1:0]  r_wr_addr;
  logic [8*WIDTH-1:0]  r_wr_data;

  logic                w_accept;
  logic                w_issue;
  logic                w_eval;
  logic                w_hit;
  logic                w_exhaust;
  logic [2:0]          w_pos;
  logic [8*WIDTH-1:0]  w_patched;
  logic                w_unused_lock;

  // Lock count from the decoder is reserved and intentionally ignored.
  assign w_unused_lock      = ^bus.dcd_lock_cnt_i;
  assign bus.dcd_value_o    = bus.rd_data_i;
  assign bus.dcd_lock_cnt_o = 2'b00;

  assign bus.found_o   = r_found;
  assign bus.var_idx_o = r_var_idx;
  assign bus.rd_addr_o = r_ptr;
  assign bus.wr_addr_o = r_wr_addr;
  assign bus.wr_data_o = r_wr_data;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_eval      = 1'b0;
    w_hit       = 1'b0;
    w_exhaust   = 1'b0;
    bus.busy_o  = 1'b0;
    bus.done_o  = 1'b0;
    bus.wr_en_o = 1'b0;
    bus.rd_en_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_i && !bus.abort_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        bus.busy_o  = 1'b1;
        w_issue     = (r_issued < c_num);
        bus.rd_en_o = w_issue;
        w_eval      = r_eval_vld;
        w_hit       = r_eval_vld && (|bus.dcd_index_i);
        w_exhaust   = r_eval_vld && !(|bus.dcd_index_i) && (r_evald == c_last);
        if (bus.abort_i)              w_state_nxt = ST_IDLE;
        else if (w_hit || w_exhaust)  w_state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        bus.busy_o  = 1'b1;
        bus.done_o  = 1'b1;
        bus.wr_en_o = r_found;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Lowest set decoder bit wins.
  always_comb begin
    w_pos = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (bus.dcd_index_i[k]) w_pos = 3'(k);
    end
  end

  always_comb begin
    w_patched = bus.rd_data_i;
    w_patched[int'(w_pos)*WIDTH +: WIDTH] = DECIDE_VALUE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_issued   <= '0;
      r_evald    <= '0;
      r_eval_vld <= 1'b0;
      r_eval_grp <= '0;
      r_last_grp <= '0;
      r_found    <= 1'b0;
      r_var_idx  <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      // Read data returns one cycle after the strobe; remember which group it is.
      r_eval_vld <= w_issue;
      r_eval_grp <= r_ptr;
      if (bus.abort_i && (r_state != ST_FINISH)) begin
        r_found <= 1'b0;
      end else if (w_accept) begin
        r_ptr    <= r_last_grp;
        r_issued <= '0;
        r_evald  <= '0;
        r_found  <= 1'b0;
      end else if (r_state == ST_SCAN) begin
        if (w_issue) begin
          r_ptr    <= r_ptr + 1'b1;
          r_issued <= r_issued + 1'b1;
        end
        if (w_eval) r_evald <= r_evald + 1'b1;
        if (w_hit) begin
          r_found    <= 1'b1;
          r_var_idx  <= {r_eval_grp, w_pos};
          r_last_grp <= r_eval_grp;
          r_wr_addr  <= r_eval_grp;
          r_wr_data  <= w_patched;
        end
      end
    end
  end

endmodule
`default_nettype wire
